// File: rtl/x25519_pkg.sv
// Shared definitions for the X25519 field datapath (p = 2^255 - 19).
// Holds the operand width, the prime, and the fold constant. Every field block
// imports this package.
package x25519_pkg;

  // Operands carry 9 bits of headroom above 2^255.
  localparam int X25519_WIDTH  = 264;

  // 2^255 == 19 (mod p). This lets bits at and above 255 fold back into the low part.
  localparam int X25519_FOLD_K = 19;

  // p = 2^255 - 19
  localparam logic [254:0] X25519_P = {255{1'b1}} - 255'd18;

  typedef logic [X25519_WIDTH-1:0] x25519_elem_t;

endpackage

// File: rtl/x25519_add_if.sv
// Operand/result bundle for the X25519 field adder.
//   en        : operand strobe; a and b are sampled on the edge where en=1
//   a, b      : 264-bit addends
//   out_valid : one-cycle pulse marking a result
//   out       : 264-bit result; bits [263:256] are always 0
// The master modport drives operands. The slave modport (the adder) drives results.
interface x25519_add_if;
  import x25519_pkg::*;

  logic         en;
  x25519_elem_t a;
  x25519_elem_t b;
  logic         out_valid;
  x25519_elem_t out;

  modport master (output en, output a, output b, input  out_valid, input  out);
  modport slave  (input  en, input  a, input  b, output out_valid, output out);

endinterface

// File: rtl/x25519_fold.sv
// Registered partial reduction stage for the X25519 field datapath.
// Takes a 265-bit sum s and produces s[254:0] + 19*s[264:255]. The result is
// congruent to s mod p and below 2^256.
// It is shared with the subtractor and multiplier output stages.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   in_valid  : s is valid this cycle
//   in        : 265-bit value to fold
//   out_valid : registered in_valid
//   out       : registered result, zero-extended to 264 bits
module x25519_fold
  import x25519_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [264:0] in,
  output logic         out_valid,
  output x25519_elem_t out
);

  // The upper part is at most 10 bits and the constant needs 5 bits,
  // so a 15-bit product is exact.
  function automatic logic [255:0] fold_p255(input logic [264:0] s);
    logic [14:0] k;
    k = 15'(s[264:255]) * 15'(X25519_FOLD_K);
    return {1'b0, s[254:0]} + {241'b0, k};
  endfunction

  logic [255:0] w_fold;
  logic         r_vld_p3;
  x25519_elem_t r_out_p3;

  assign w_fold = fold_p255(in);

  // ---- stage 3: fold and register the result ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p3 <= 1'b0;
      r_out_p3 <= '0;
    end else begin
      r_vld_p3 <= in_valid;
      if (in_valid) r_out_p3 <= {8'h00, w_fold};
    end
  end

  assign out_valid = r_vld_p3;
  assign out       = r_out_p3;

endmodule

// File: rtl/x25519_add.sv
// Pipelined modular adder for the X25519 field, p = 2^255 - 19.
// Accepts one operand pair per cycle and has a fixed latency of 3 cycles.
// The result is congruent to a+b mod p and below 2^256. Reduction is partial,
// so results in [p, 2^256) can appear.
// Ports:
//   clk  : datapath clock
//   rst  : asynchronous active-high reset; clears all in-flight work at once
//   bus  : x25519_add_if slave (en, a, b in; out_valid, out out)
// Stage 1 adds the low 132 bits. Stage 2 adds the high 132 bits plus the carry.
// Stage 3 (x25519_fold) folds bits [264:255] back into the low part using the constant 19.
module x25519_add
  import x25519_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  x25519_add_if.slave    bus
);

  logic [132:0] w_lo;
  logic [132:0] w_hi;

  logic         r_vld_p1;
  logic [132:0] r_lo_p1;
  logic [131:0] r_ahi_p1;
  logic [131:0] r_bhi_p1;

  logic         r_vld_p2;
  logic [264:0] r_sum_p2;

  logic         w_out_valid;
  x25519_elem_t w_out;

  assign w_lo = {1'b0, bus.a[131:0]} + {1'b0, bus.b[131:0]};
  assign w_hi = {1'b0, r_ahi_p1} + {1'b0, r_bhi_p1} + {132'b0, r_lo_p1[132]};

  // ---- stage 1: low-half add, high halves carried forward ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
      r_lo_p1  <= '0;
      r_ahi_p1 <= '0;
      r_bhi_p1 <= '0;
    end else begin
      r_vld_p1 <= bus.en;
      if (bus.en) begin
        r_lo_p1  <= w_lo;
        r_ahi_p1 <= bus.a[263:132];
        r_bhi_p1 <= bus.b[263:132];
      end
    end
  end

  // ---- stage 2: high-half add with low carry, full 265-bit sum ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p2 <= 1'b0;
      r_sum_p2 <= '0;
    end else begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) r_sum_p2 <= {w_hi, r_lo_p1[131:0]};
    end
  end

  x25519_fold u_fold (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (r_vld_p2),
    .in        (r_sum_p2),
    .out_valid (w_out_valid),
    .out       (w_out)
  );

  assign bus.out_valid = w_out_valid;
  assign bus.out       = w_out;

endmodule
